// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions.
//   NOP_INSTR     : instruction word presented to decode when the buffer is empty
//                   (sll $0,$0,0).
//   PC_INCR       : sequential PC increment.
//   fetch_entry_t : one {pc, instr} pair as captured from the fetch stage.
package mips_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam int          PC_INCR   = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/if_id_fetch_buffer_sat_counter.sv
// sat_counter: W-bit up counter that increments on inc and sticks at all-ones.
//   CLK   : clock, rising edge
//   RST   : asynchronous reset, active-low (count -> 0)
//   inc   : increment request this cycle
//   count : current value
module sat_counter #(
    parameter int W = 32
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST)
            count <= '0;
        else if (inc && (count != {W{1'b1}}))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/if_id_fetch_buffer.sv
// if_id_fetch_buffer: buffered IF/ID stage. Captures {pc, instr} from fetch into a
// DEPTH-entry circular FIFO and presents the head to decode with valid/ready.
// pc_n_en (active-low PC load enable) freezes the PC while the buffer is full.
// flush discards all buffered entries (taken branch/jump).
//
// Ports:
//   CLK, RST              : clock (rising), async active-low reset
//   in_valid/in_pc/in_instr/in_ready : fetch-side handshake
//   pc_n_en               : ~in_ready
//   flush                 : drop all entries, has priority over push/pop
//   out_valid/out_ready/out_pc/out_pc_plus4/out_instr : decode-side handshake
//
// Build option IFID_PERF_CNT_EN adds stall_cycles and flush_count (32-bit,
// saturating, not cleared by flush).
module if_id_fetch_buffer
    import mips_pkg::*;
#(
    parameter int N     = 32,
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         in_valid,
    input  logic [N-1:0] in_pc,
    input  logic [N-1:0] in_instr,
    output logic         in_ready,
    output logic         pc_n_en,
    input  logic         flush,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_pc,
    output logic [N-1:0] out_pc_plus4,
    output logic [N-1:0] out_instr
`ifdef IFID_PERF_CNT_EN
    ,
    output logic [31:0]  stall_cycles,
    output logic [31:0]  flush_count
`endif
);

    typedef struct packed {
        logic [N-1:0] pc;
        logic [N-1:0] instr;
    } entry_t;

    entry_t             mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [PTR_W:0]     count;
    logic               push, pop;

    // Ready depends on registered state only: no decode -> PC combinational path.
    assign in_ready  = (count != (PTR_W+1)'(DEPTH));
    assign pc_n_en   = ~in_ready;
    assign out_valid = (count != '0);

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (flush) begin
            // Contents are left in place; only the bookkeeping is reset.
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= '{pc: in_pc, instr: in_instr};
                wr_ptr      <= wr_ptr + 1'b1;  // DEPTH is a power of two: natural wrap
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Empty buffer presents a NOP at PC 0 so decode sees a harmless bubble.
    always_comb begin
        out_pc    = '0;
        out_instr = N'(NOP_INSTR);
        if (out_valid) begin
            out_pc    = mem[rd_ptr].pc;
            out_instr = mem[rd_ptr].instr;
        end
    end

    assign out_pc_plus4 = out_pc + N'(PC_INCR);

`ifdef IFID_PERF_CNT_EN
    sat_counter #(.W(32)) u_stall_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (in_valid & ~in_ready),
        .count (stall_cycles)
    );

    sat_counter #(.W(32)) u_flush_cnt (
        .CLK   (CLK),
        .RST   (RST),
        .inc   (flush),
        .count (flush_count)
    );
`endif

endmodule

// File: tb/tb_if_id_fetch_buffer.sv
module tb_if_id_fetch_buffer;

    logic        CLK = 1'b0;
    logic        RST;
    logic        in_valid, in_ready, pc_n_en, flush;
    logic        out_valid, out_ready;
    logic [31:0] in_pc, in_instr, out_pc, out_pc_plus4, out_instr;
`ifdef IFID_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_count;
`endif

    if_id_fetch_buffer #(.N(32), .DEPTH(2)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .in_valid     (in_valid),
        .in_pc        (in_pc),
        .in_instr     (in_instr),
        .in_ready     (in_ready),
        .pc_n_en      (pc_n_en),
        .flush        (flush),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_pc       (out_pc),
        .out_pc_plus4 (out_pc_plus4),
        .out_instr    (out_instr)
`ifdef IFID_PERF_CNT_EN
        ,
        .stall_cycles (stall_cycles),
        .flush_count  (flush_count)
`endif
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int pops   = 0;
    logic [63:0] exp_q [$];   // {pc, instr} expected in decode order

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic push_exp(input logic [31:0] pc, input logic [31:0] instr);
        exp_q.push_back({pc, instr});
    endtask

    // Monitor: a pop happens at the next edge whenever decode takes the head.
    always @(negedge CLK) begin
        if (RST && out_valid && out_ready && !flush) begin
            logic [63:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_pop: got pc %h expected none", out_pc);
            end else begin
                e = exp_q.pop_front();
                chk("mon_pc",    out_pc,       e[63:32]);
                chk("mon_instr", out_instr,    e[31:0]);
                chk("mon_plus4", out_pc_plus4, e[63:32] + 32'd4);
                pops++;
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int guard;
        RST = 1'b0; in_valid = 0; in_pc = 0; in_instr = 0; flush = 0; out_ready = 0;
        #12;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
        chk("rst_pc_n_en",   {31'd0, pc_n_en},   32'd0);
        chk("rst_out_pc",    out_pc,             32'd0);
        chk("rst_plus4",     out_pc_plus4,       32'd4);
        chk("rst_instr",     out_instr,          32'd0);
        RST = 1'b1;
        step();

        // Reset mid-stream
        in_valid = 1; in_pc = 32'h10; in_instr = 32'h2008_0005;
        step();
        in_valid = 0;
        chk("mid_valid_before", {31'd0, out_valid}, 32'd1);
        chk("mid_pc_before",    out_pc,             32'h10);
        #2 RST = 1'b0;
        #1;
        chk("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, in_ready},  32'd1);
        chk("mid_rst_pc",    out_pc,             32'd0);
        chk("mid_rst_plus4", out_pc_plus4,       32'd4);
        RST = 1'b1;
        step();

        // Streaming
        out_ready = 1;
        for (int i = 0; i < 3; i++) begin
            in_valid = 1; in_pc = 32'(i * 4); in_instr = 32'h1000 + 32'(i);
            push_exp(in_pc, in_instr);
            step();
            chk("stream_in_ready", {31'd0, in_ready}, 32'd1);
        end
        in_valid = 0;
        step(); step();
        out_ready = 0;

        // Full / backpressure
        in_valid = 1; in_pc = 32'h20; in_instr = 32'hA0; push_exp(in_pc, in_instr); step();
        in_pc = 32'h24; in_instr = 32'hA4; push_exp(in_pc, in_instr); step();
        chk("full_in_ready", {31'd0, in_ready}, 32'd0);
        chk("full_pc_n_en",  {31'd0, pc_n_en},  32'd1);
        in_pc = 32'h28; in_instr = 32'hA8;
        step();
        chk("full_hold_ready", {31'd0, in_ready}, 32'd0);
        chk("full_hold_head",  out_pc,            32'h20);
        out_ready = 1;
        step();
        out_ready = 0;
        chk("full_freed_ready", {31'd0, in_ready}, 32'd1);
        chk("full_head_after",  out_pc,            32'h24);
        push_exp(32'h28, 32'hA8);
        step();
        in_valid = 0;
        out_ready = 1;
        step(); step();
        out_ready = 0;
        chk("full_drained", {31'd0, out_valid}, 32'd0);

        // Flush priority
        in_valid = 1; in_pc = 32'h30; in_instr = 32'hB0;
        step();
        flush = 1; in_pc = 32'h34; in_instr = 32'hB4; out_ready = 1;
        step();
        flush = 0; in_valid = 0; out_ready = 0;
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_ready", {31'd0, in_ready},  32'd1);
        in_valid = 1; in_pc = 32'h80; in_instr = 32'hC0; push_exp(in_pc, in_instr);
        step();
        in_valid = 0;
        chk("flush_next_head", out_pc, 32'h80);
        out_ready = 1;
        step();
        out_ready = 0;

        // Wrap-around with alternating backpressure
        for (int i = 0; i < 5; i++) begin
            out_ready = i[0];
            guard = 0;
            while (!in_ready && guard < 10) begin
                out_ready = 1; in_valid = 0; step(); guard++;
            end
            if (guard >= 10) chk("wrap_timeout", 32'd1, 32'd0);
            in_valid = 1; in_pc = 32'h40 + 32'(i * 4); in_instr = 32'hD0 + 32'(i);
            push_exp(in_pc, in_instr);
            step();
            in_valid = 0;
        end
        out_ready = 1;
        for (int i = 0; i < 4; i++) step();
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // PC wrap in out_pc_plus4
        out_ready = 0;
        in_valid = 1; in_pc = 32'hFFFF_FFFC; in_instr = 32'hE0; push_exp(in_pc, in_instr);
        step();
        in_valid = 0;
        chk("wrap_plus4", out_pc_plus4, 32'd0);
        out_ready = 1;
        step();
        out_ready = 0;
        // 3 streaming + 3 full + 1 flush-path + 5 wrap + 1 top-of-range
        chk("pop_total", 32'(pops), 32'd13);

`ifdef IFID_PERF_CNT_EN
        begin
            logic [31:0] s0, f0;
            in_valid = 1; in_pc = 32'h100; in_instr = 0; step();
            in_pc = 32'h104; step();
            s0 = stall_cycles;
            in_pc = 32'h108;
            step(); step(); step();
            in_valid = 0;
            chk("perf_stall", stall_cycles - s0, 32'd3);
            f0 = flush_count;
            flush = 1; step(); flush = 0; step(); flush = 1; step(); flush = 0;
            chk("perf_flush", flush_count - f0, 32'd2);
        end
`endif

        step();
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_fetch_buffer.md
Name: if_id_fetch_buffer

Overview:
- Buffered IF/ID pipeline stage that sits directly downstream of the program counter register.
- Captures {pc, instruction} pairs from the fetch stage into a small circular FIFO and presents them to decode with a valid/ready handshake.
- Generates the active-low PC load-enable (pc_n_en), which freezes the PC while the buffer is full.
- Supports a branch/jump flush from later stages.

Parameters:
- N, 32, width of PC and instruction words.
- DEPTH, 2, number of buffer entries; power of two, minimum 2.
- PTR_W, $clog2(DEPTH), read/write pointer width (derived; not overridden).

Ports:
- CLK  input  1  clock, rising edge.
- RST  input  1  reset, asynchronous, active-low.
- in_valid  input  1  fetch stage presents a valid pc/instr this cycle.
- in_pc  input  N  PC of fetched instruction (PC register output).
- in_instr  input  N  instruction word from instruction memory.
- in_ready  output  1  buffer can accept an entry this cycle.
- pc_n_en  output  1  PC load enable, active-low; equals ~in_ready.
- flush  input  1  discard all buffered entries (taken branch/jump).
- out_valid  output  1  head entry valid for decode.
- out_ready  input  1  decode accepts the head entry this cycle.
- out_pc  output  N  PC of head entry.
- out_pc_plus4  output  N  out_pc + 4, modulo 2^N.
- out_instr  output  N  instruction of head entry.

Behaviour:
- Storage: DEPTH entries of {pc, instr}; wr_ptr, rd_ptr (PTR_W bits, wrap modulo DEPTH); count (PTR_W+1 bits, 0..DEPTH).
- Reset (RST low, asynchronous): count=0, wr_ptr=rd_ptr=0, all entries cleared to 0.
- Outputs during reset: out_valid=0, in_ready=1, pc_n_en=0, out_pc=0, out_pc_plus4=4, out_instr=0.
- in_ready = (count != DEPTH). It is derived from registered state only and never depends on out_ready, so there is no combinational path from decode to the PC.
- push = in_valid & in_ready & ~flush.
- pop = out_valid & out_ready & ~flush.
- Latency: an entry pushed at edge k has out_valid=1 after edge k. Minimum fetch-to-decode latency is 1 cycle.
- Simultaneous push and pop (count between 1 and DEPTH-1): both pointers advance, count unchanged.
- Full (count==DEPTH): in_ready=0 and pc_n_en=1, so the PC holds. A pop that cycle frees one slot; in_ready rises the next cycle.
- Empty (count==0): out_valid=0, out_pc=0, out_instr=0 (NOP, sll $0,$0,0), out_pc_plus4=4. out_ready is ignored.
- Flush: at the edge, count=0 and wr_ptr=rd_ptr=0. Any push or pop requested in the same cycle is dropped. Entry contents are not cleared. After the edge, out_valid=0 and in_ready=1.
- Flush has priority over push and pop. Reset has priority over everything.
- Arithmetic: out_pc_plus4 is computed combinationally from the head entry and wraps at 2^N (0xFFFFFFFC+4=0).
- No pointer overflow is possible. Push is impossible when full; pop is impossible when empty.
- Entry data is unchanged while held; stable-while-valid-and-not-ready holds on the output side.

Optional Feature:
- Macro: IFID_PERF_CNT_EN.
- With the macro defined, two extra output ports are added:
  - stall_cycles, 32 bits: increments each cycle with in_valid & ~in_ready.
  - flush_count, 32 bits: increments each cycle flush=1.
  - Both reset to 0, saturate at 0xFFFFFFFF, and are not cleared by flush.
- Without the macro, both ports and their counters are absent; all other behaviour is identical.

Decomposition:
- Shared package (mips_pkg):
  - NOP_INSTR = 32'h0000_0000.
  - PC_INCR = 4.
  - Typedef fetch_entry_t {pc, instr}.
- Sub-module: sat_counter (parameter W; inc input, count output, saturating). It is instantiated twice, only under IFID_PERF_CNT_EN.
- The FIFO core stays inline.

Test Plan:
- Reset mid-stream: fill 1 entry (pc=0x10, instr=0x2008_0005), assert RST low between edges -> out_valid=0 and in_ready=1 immediately, out_pc=0, out_pc_plus4=4.
- Streaming: out_ready=1, push pc=0x00,0x04,0x08 on consecutive cycles -> out_pc=0x00,0x04,0x08 one cycle later each, out_pc_plus4=0x04,0x08,0x0C, in_ready stays 1.
- Full/backpressure: out_ready=0, push pc=0x20 and 0x24 -> count=2, in_ready=0, pc_n_en=1. A third in_valid (pc=0x28) is not accepted. Raise out_ready for 1 cycle -> 0x20 pops, in_ready=1 next cycle, 0x28 accepted next.
- Flush priority: count=1 (pc=0x30); in one cycle assert flush, in_valid (pc=0x34) and out_ready -> after the edge out_valid=0, count=0. Next push pc=0x80 appears as head, with no 0x34 ever output.
- Wrap-around: push and pop 5 entries through the DEPTH=2 buffer with alternating out_ready -> output order 0x40..0x50 preserved, no duplicates or drops. Also drive in_pc=0xFFFFFFFC -> out_pc_plus4=0.
- IFID_PERF_CNT_EN build: hold full with in_valid=1 for 3 cycles, then pulse flush twice -> stall_cycles=3, flush_count=2.
